mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of the data-memory port.
REQ-002 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port ex_valid  input  1  EX stage presents an operation.
REQ-005 SHALL have port ex_op  input  4  mem_op_t: NONE, LB, LH, LW, LBU, LHU, SB, SH, SW.
REQ-006 SHALL have port ex_wa  input  5  destination register.
REQ-007 SHALL have port ex_we  input  1  operation writes the register file.
REQ-008 SHALL have port ex_result  input  32  ALU result; effective address for loads and stores.
REQ-009 SHALL have port ex_sdata  input  32  store data, rs2 value.
REQ-010 SHALL have port ex_ready  output  1  stage accepts an operation this cycle.
REQ-011 SHALL have ports mem_req, mem_we (output 1), mem_addr (output ADDR_W), mem_wdata (output 32), mem_wstrb (output 4): data-memory request.
REQ-012 SHALL have ports mem_ack (input 1) and mem_rdata (input 32): memory completion and read data.
REQ-013 SHALL have ports wb_we (output 1), wb_wa (output 5), wb_wn (output 32): register-file write port.
REQ-014 SHALL have port mem_err  output  1  misaligned-access flag.

Function
REQ-015 SHALL implement FSM IDLE and BUSY; transfer occurs when ex_valid && ex_ready; ex_ready SHALL equal (state==IDLE).
REQ-016 For NONE accepted in IDLE: next cycle wb_we=ex_we&&(ex_wa!=0), wb_wa=ex_wa, wb_wn=ex_result; stay IDLE; one-cycle latency.
REQ-017 For load or store accepted in IDLE: latch op/wa/we/address/data, enter BUSY; mem_req=1 exactly while BUSY, outputs stable until mem_ack.
REQ-018 mem_addr SHALL be the latched address with bits [1:0] forced to 0; mem_we=1 only for stores.
REQ-019 Stores: mem_wstrb SB=0001<<a[1:0], SH=0011<<a[1:0], SW=1111; mem_wdata SHALL replicate byte/half across lanes; loads drive mem_wstrb=0000.
REQ-020 mem_ack is sampled only in BUSY; mem_ack in the first BUSY cycle is legal; on ack -> IDLE.
REQ-021 Load completion: cycle after ack, wb_we=1 (if latched wa!=0), wb_wn = lane selected by a[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-022 Store completion SHALL NOT assert wb_we.
REQ-023 wb_we SHALL be a registered one-cycle pulse; otherwise 0, wb_wa/wb_wn hold last value.
REQ-024 Minimum load latency: accept cycle N, mem_req cycle N+1, ack N+1, wb_we cycle N+2; throughput at most one memory op per 2 cycles.
REQ-025 ex_valid=0 in IDLE SHALL produce no state change and wb_we=0.

Reset
REQ-026 On rst: state IDLE, mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, wb_we=0, wb_wa=0, wb_wn=0, mem_err=0.
REQ-027 rst during BUSY SHALL abandon the access; no write-back of the pending load; mem_req low the cycle after reset is sampled.

Configuration
REQ-028 Macro MEM_MISALIGN_TRAP_EN defined: LH/LHU/SH with a[0]=1 or LW/SW with a[1:0]!=0 SHALL not enter BUSY, SHALL pulse mem_err one cycle after accept, SHALL not write back.
REQ-029 Macro undefined: mem_err tied 0; misaligned halfwords use lane a[1], words use lane 0.

Structure
REQ-030 Package mem_pkg SHALL hold mem_op_t encodings, the is_load/is_store helpers and the FSM state type.
REQ-031 Sub-module load_align SHALL hold the combinational lane select and sign/zero extension for REQ-021.

Verification
REQ-032 NONE, wa=5, result=0x1234 -> next cycle wb_we=1, wb_wa=5, wb_wn=0x1234.
REQ-033 SB addr 0x103, sdata 0xAB -> mem_addr 0x100, wstrb 1000, wdata 0xABABABAB, no wb_we.
REQ-034 LB addr 0x102, rdata 0x00800000, ack after 3 BUSY cycles -> wb_wn 0xFFFFFF80; LBU -> 0x00000080.
REQ-035 LW to wa=0 with ack -> wb_we stays 0; ex_ready returns 1 the cycle after ack.
REQ-036 rst asserted in the second BUSY cycle of LW -> mem_req 0 next cycle, no wb_we.
REQ-037 With MEM_MISALIGN_TRAP_EN, LW addr 0x102 -> mem_err pulse, mem_req never asserted.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the data-memory pipeline stage: op encodings,
// FSM states and op classification helpers.
package mem_pkg;

   typedef enum logic [3:0] {
      OP_NONE = 4'd0,
      OP_LB   = 4'd1,
      OP_LH   = 4'd2,
      OP_LW   = 4'd3,
      OP_LBU  = 4'd4,
      OP_LHU  = 4'd5,
      OP_SB   = 4'd6,
      OP_SH   = 4'd7,
      OP_SW   = 4'd8
   } mem_op_t;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   function automatic logic is_load(mem_op_t op);
      return (op == OP_LB)  || (op == OP_LH)  ||
             (op == OP_LW)  || (op == OP_LBU) ||
             (op == OP_LHU);
   endfunction

   function automatic logic is_store(mem_op_t op);
      return (op == OP_SB) || (op == OP_SH) ||
             (op == OP_SW);
   endfunction

   function automatic logic is_misaligned(
      mem_op_t    op,
      logic [1:0] a
   );
      logic w_half;
      logic w_word;
      w_half = (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_SH);
      w_word = (op == OP_LW) || (op == OP_SW);
      return (w_half && a[0]) ||
             (w_word && (a != 2'b00));
   endfunction

endpackage

// File: rtl/load_align.sv
// Load lane select and sign/zero extension.
// Halfwords take the lane chosen by a[1]; words pass through.
module load_align
   import mem_pkg::*;
(
   input  logic [3:0]  i_op,
   input  logic [1:0]  i_addr,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_byte = i_rdata[{i_addr, 3'b000} +: 8];
   assign w_half = i_addr[1] ? i_rdata[31:16]
                             : i_rdata[15:0];

   always_comb begin
      o_data = i_rdata;
      case (mem_op_t'(i_op))
         OP_LB:   o_data = {{24{w_byte[7]}}, w_byte};
         OP_LBU:  o_data = {24'h0, w_byte};
         OP_LH:   o_data = {{16{w_half[15]}}, w_half};
         OP_LHU:  o_data = {16'h0, w_half};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: one outstanding data-memory access, then write-back.
// Define MEM_MISALIGN_TRAP_EN to flag misaligned accesses on mem_err.
module mem_stage
   import mem_pkg::*;
#(
   parameter int ADDR_W = 32
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   input  logic [3:0]        ex_op,
   input  logic [4:0]        ex_wa,
   input  logic              ex_we,
   input  logic [31:0]       ex_result,
   input  logic [31:0]       ex_sdata,
   output logic              ex_ready,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_wstrb,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata,
   output logic              wb_we,
   output logic [4:0]        wb_wa,
   output logic [31:0]       wb_wn,
   output logic              mem_err
);

   state_t            r_state;
   state_t            w_state_nxt;
   mem_op_t           r_op;
   logic [4:0]        r_wa;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_sdata;
   logic              r_wb_we;
   logic [4:0]        r_wb_wa;
   logic [31:0]       r_wb_wn;
   logic              r_err;

   mem_op_t     w_op;
   logic        w_accept;
   logic        w_mem;
   logic        w_trap;
   logic        w_busy;
   logic        w_done;
   logic [31:0] w_load;

   assign w_op     = mem_op_t'(ex_op);
   assign w_busy   = (r_state == S_BUSY);
   assign ex_ready = (r_state == S_IDLE);
   assign w_accept = ex_valid && ex_ready;
   assign w_mem    = is_load(w_op) || is_store(w_op);
   assign w_done   = w_busy && mem_ack;

`ifdef MEM_MISALIGN_TRAP_EN
   assign w_trap = is_misaligned(w_op, ex_result[1:0]);
`else
   assign w_trap = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:
            if (w_accept && w_mem && !w_trap)
               w_state_nxt = S_BUSY;
         S_BUSY:
            if (mem_ack)
               w_state_nxt = S_IDLE;
         default:
            w_state_nxt = S_IDLE;
      endcase
   end

   load_align u_align (
      .i_op    (r_op),
      .i_addr  (r_addr[1:0]),
      .i_rdata (mem_rdata),
      .o_data  (w_load)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_op    <= OP_NONE;
         r_wa    <= 5'd0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_sdata <= 32'h0;
         r_wb_we <= 1'b0;
         r_wb_wa <= 5'd0;
         r_wb_wn <= 32'h0;
         r_err   <= 1'b0;
      end else begin
         r_wb_we <= 1'b0;
         r_err   <= 1'b0;
         if (w_accept) begin
            if (!w_mem) begin
               r_wb_we <= ex_we && (ex_wa != 5'd0);
               r_wb_wa <= ex_wa;
               r_wb_wn <= ex_result;
            end else if (w_trap) begin
               r_err <= 1'b1;
            end else begin
               r_op    <= w_op;
               r_wa    <= ex_wa;
               r_we    <= ex_we;
               r_addr  <= ADDR_W'(ex_result);
               r_sdata <= ex_sdata;
            end
         end
         // Loads retire the cycle after ack; stores retire silently.
         if (w_done && is_load(r_op)) begin
            r_wb_we <= r_we && (r_wa != 5'd0);
            r_wb_wa <= r_wa;
            r_wb_wn <= w_load;
         end
      end
   end

   assign mem_req  = w_busy;
   assign mem_we   = w_busy && is_store(r_op);
   assign mem_addr = {r_addr[ADDR_W-1:2], 2'b00};

   always_comb begin
      mem_wdata = r_sdata;
      case (r_op)
         OP_SB:   mem_wdata = {4{r_sdata[7:0]}};
         OP_SH:   mem_wdata = {2{r_sdata[15:0]}};
         default: mem_wdata = r_sdata;
      endcase
   end

   always_comb begin
      mem_wstrb = 4'b0000;
      if (w_busy) begin
         case (r_op)
            OP_SB:   mem_wstrb = 4'b0001 << r_addr[1:0];
            OP_SH:   mem_wstrb = 4'b0011 << r_addr[1:0];
            OP_SW:   mem_wstrb = 4'b1111;
            default: mem_wstrb = 4'b0000;
         endcase
      end
   end

   assign wb_we   = r_wb_we;
   assign wb_wa   = r_wb_wa;
   assign wb_wn   = r_wb_wn;
   assign mem_err = r_err;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: transaction-level reference model
// compared every cycle, plus directed literal expectations.
module tb_mem_stage;

   localparam logic [3:0] NONE = 4'd0;
   localparam logic [3:0] LB   = 4'd1;
   localparam logic [3:0] LH   = 4'd2;
   localparam logic [3:0] LW   = 4'd3;
   localparam logic [3:0] LBU  = 4'd4;
   localparam logic [3:0] LHU  = 4'd5;
   localparam logic [3:0] SB   = 4'd6;
   localparam logic [3:0] SH   = 4'd7;
   localparam logic [3:0] SW   = 4'd8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ex_valid = 1'b0;
   logic [3:0]  ex_op = NONE;
   logic [4:0]  ex_wa = 5'd0;
   logic        ex_we = 1'b0;
   logic [31:0] ex_result = 32'h0;
   logic [31:0] ex_sdata = 32'h0;
   logic        ex_ready;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ack = 1'b0;
   logic [31:0] mem_rdata = 32'h0;
   logic        wb_we;
   logic [4:0]  wb_wa;
   logic [31:0] wb_wn;
   logic        mem_err;

   always #5 clk = ~clk;

   mem_stage #(.ADDR_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .ex_valid  (ex_valid),
      .ex_op     (ex_op),
      .ex_wa     (ex_wa),
      .ex_we     (ex_we),
      .ex_result (ex_result),
      .ex_sdata  (ex_sdata),
      .ex_ready  (ex_ready),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_wstrb (mem_wstrb),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .wb_we     (wb_we),
      .wb_wa     (wb_wa),
      .wb_wn     (wb_wn),
      .mem_err   (mem_err)
   );

   int n_chk = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   task automatic check(input string nm,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h",
                  nm, act, exp);
      end
   endtask

   function automatic bit is_ld(logic [3:0] op);
      return op == LB || op == LH || op == LW ||
             op == LBU || op == LHU;
   endfunction

   function automatic bit is_st(logic [3:0] op);
      return op == SB || op == SH || op == SW;
   endfunction

   function automatic bit misal(logic [3:0] op, logic [1:0] a);
      if (op == LH || op == LHU || op == SH) return a[0];
      if (op == LW || op == SW) return a != 2'd0;
      return 1'b0;
   endfunction

   function automatic logic [3:0] m_strb(logic [3:0] op,
                                         logic [1:0] a);
      logic [7:0] s;
      s = 8'd0;
      if (op == SB) s = 8'd1 << a;
      if (op == SH) s = 8'd3 << a;
      if (op == SW) s = 8'd15;
      return s[3:0];
   endfunction

   function automatic logic [31:0] m_wdata(logic [3:0] op,
                                           logic [31:0] d);
      if (op == SB) return (d & 32'hFF) * 32'h01010101;
      if (op == SH) return (d & 32'hFFFF) * 32'h00010001;
      return d;
   endfunction

   function automatic logic [31:0] m_load(logic [3:0] op,
                                          logic [1:0] a,
                                          logic [31:0] d);
      logic [31:0] b;
      logic [31:0] h;
      b = (d >> (8 * a)) & 32'hFF;
      h = (d >> (16 * a[1])) & 32'hFFFF;
      case (op)
         LB:  return b[7] ? (b | 32'hFFFFFF00) : b;
         LBU: return b;
         LH:  return h[15] ? (h | 32'hFFFF0000) : h;
         LHU: return h;
         default: return d;
      endcase
   endfunction

   bit          m_busy = 1'b0;
   logic [3:0]  m_op = NONE;
   logic [4:0]  m_wa = 5'd0;
   bit          m_we = 1'b0;
   logic [31:0] m_addr = 32'h0;
   logic [31:0] m_sd = 32'h0;
   bit          e_wbwe = 1'b0;
   logic [4:0]  e_wa = 5'd0;
   logic [31:0] e_wn = 32'h0;
   bit          e_err = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         m_busy <= 1'b0;
         m_op   <= NONE;
         m_addr <= 32'h0;
         e_wbwe <= 1'b0;
         e_wa   <= 5'd0;
         e_wn   <= 32'h0;
         e_err  <= 1'b0;
      end else begin
         e_wbwe <= 1'b0;
         e_err  <= 1'b0;
         if (m_busy) begin
            if (mem_ack) begin
               m_busy <= 1'b0;
               if (is_ld(m_op)) begin
                  e_wbwe <= m_we && (m_wa != 5'd0);
                  e_wa   <= m_wa;
                  e_wn   <= m_load(m_op, m_addr[1:0], mem_rdata);
               end
            end
         end else if (ex_valid) begin
            if (!is_ld(ex_op) && !is_st(ex_op)) begin
               e_wbwe <= ex_we && (ex_wa != 5'd0);
               e_wa   <= ex_wa;
               e_wn   <= ex_result;
            end
`ifdef MEM_MISALIGN_TRAP_EN
            else if (misal(ex_op, ex_result[1:0])) begin
               e_err <= 1'b1;
            end
`endif
            else begin
               m_busy <= 1'b1;
               m_op   <= ex_op;
               m_wa   <= ex_wa;
               m_we   <= ex_we;
               m_addr <= ex_result;
               m_sd   <= ex_sdata;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("ex_ready", ex_ready, m_busy ? 0 : 1);
         check("mem_req", mem_req, m_busy);
         check("mem_we", mem_we, m_busy && is_st(m_op));
         check("mem_wstrb", mem_wstrb,
               m_busy ? m_strb(m_op, m_addr[1:0]) : 4'd0);
         if (m_busy)
            check("mem_addr", mem_addr, m_addr & ~32'd3);
         if (m_busy && is_st(m_op))
            check("mem_wdata", mem_wdata, m_wdata(m_op, m_sd));
         check("wb_we", wb_we, e_wbwe);
         if (e_wbwe) begin
            check("wb_wa", wb_wa, e_wa);
            check("wb_wn", wb_wn, e_wn);
         end
         check("mem_err", mem_err, e_err);
      end
   end

   task automatic issue(input logic [3:0] op,
                        input logic [4:0] wa,
                        input logic we,
                        input logic [31:0] res,
                        input logic [31:0] sd);
      ex_valid  = 1'b1;
      ex_op     = op;
      ex_wa     = wa;
      ex_we     = we;
      ex_result = res;
      ex_sdata  = sd;
      @(posedge clk); #1;
      ex_valid  = 1'b0;
      ex_op     = NONE;
   endtask

   task automatic ack(input int waits, input logic [31:0] rd);
      ex_valid  = 1'b1;
      ex_op     = NONE;
      ex_wa     = 5'd9;
      ex_we     = 1'b1;
      ex_result = 32'hDEAD0000;
      repeat (waits) begin
         @(posedge clk); #1;
      end
      mem_ack   = 1'b1;
      mem_rdata = rd;
      @(posedge clk); #1;
      mem_ack   = 1'b0;
      mem_rdata = 32'h5A5A5A5A;
      ex_valid  = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      check("rst_ready", ex_ready, 1);
      check("rst_req", mem_req, 0);
      check("rst_we", mem_we, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_wdata", mem_wdata, 0);
      check("rst_wstrb", mem_wstrb, 0);
      check("rst_wbwe", wb_we, 0);
      check("rst_wbwa", wb_wa, 0);
      check("rst_wbwn", wb_wn, 0);
      check("rst_err", mem_err, 0);
      rst = 1'b0;

      issue(NONE, 5'd5, 1'b1, 32'h1234, 32'h0);
      check("none_we", wb_we, 1);
      check("none_wa", wb_wa, 5);
      check("none_wn", wb_wn, 32'h1234);
      @(posedge clk); #1;
      check("none_pulse", wb_we, 0);

      issue(SB, 5'd1, 1'b0, 32'h103, 32'hAB);
      check("sb_req", mem_req, 1);
      check("sb_we", mem_we, 1);
      check("sb_addr", mem_addr, 32'h100);
      check("sb_strb", mem_wstrb, 4'b1000);
      check("sb_wdata", mem_wdata, 32'hABABABAB);
      ack(1, 32'h0);
      check("sb_nowb", wb_we, 0);
      check("sb_ready", ex_ready, 1);

      issue(LB, 5'd7, 1'b1, 32'h102, 32'h0);
      check("lb_req", mem_req, 1);
      check("lb_strb", mem_wstrb, 0);
      ack(3, 32'h00800000);
      check("lb_we", wb_we, 1);
      check("lb_wa", wb_wa, 7);
      check("lb_wn", wb_wn, 32'hFFFFFF80);

      issue(LBU, 5'd7, 1'b1, 32'h102, 32'h0);
      ack(0, 32'h00800000);
      check("lbu_we", wb_we, 1);
      check("lbu_wn", wb_wn, 32'h00000080);

      issue(LW, 5'd0, 1'b1, 32'h200, 32'h0);
      ack(0, 32'hCAFEF00D);
      check("lw0_nowb", wb_we, 0);
      check("lw0_ready", ex_ready, 1);

      issue(LW, 5'd10, 1'b1, 32'h204, 32'h0);
      ack(2, 32'hCAFEF00D);
      check("lw_wn", wb_wn, 32'hCAFEF00D);

      issue(LH, 5'd11, 1'b1, 32'h102, 32'h0);
      ack(0, 32'h80010000);
      check("lh_wn", wb_wn, 32'hFFFF8001);

      issue(LHU, 5'd12, 1'b1, 32'h102, 32'h0);
      ack(0, 32'h80010000);
      check("lhu_wn", wb_wn, 32'h00008001);

      issue(SH, 5'd0, 1'b0, 32'h102, 32'h1234CDEF);
      check("sh_strb", mem_wstrb, 4'b1100);
      check("sh_wdata", mem_wdata, 32'hCDEFCDEF);
      ack(0, 32'h0);

      issue(SW, 5'd0, 1'b0, 32'h300, 32'h11223344);
      check("sw_strb", mem_wstrb, 4'b1111);
      check("sw_wdata", mem_wdata, 32'h11223344);
      ack(1, 32'h0);

      issue(NONE, 5'd4, 1'b0, 32'h77, 32'h0);
      check("none_nowe", wb_we, 0);
      issue(NONE, 5'd0, 1'b1, 32'h78, 32'h0);
      check("none_wa0", wb_we, 0);

      mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      check("idle_ack_req", mem_req, 0);
      check("idle_ack_ready", ex_ready, 1);

      issue(LW, 5'd3, 1'b1, 32'h400, 32'h0);
      @(posedge clk); #1;
      check("rst_busy_req", mem_req, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_abort_req", mem_req, 0);
      check("rst_abort_wb", wb_we, 0);
      @(posedge clk); #1;
      check("rst_abort_wb2", wb_we, 0);

`ifdef MEM_MISALIGN_TRAP_EN
      issue(LW, 5'd6, 1'b1, 32'h102, 32'h0);
      check("trap_err", mem_err, 1);
      check("trap_req", mem_req, 0);
      check("trap_ready", ex_ready, 1);
      @(posedge clk); #1;
      check("trap_err_pulse", mem_err, 0);
      check("trap_nowb", wb_we, 0);
      check("trap_req2", mem_req, 0);
      issue(SH, 5'd0, 1'b0, 32'h101, 32'h0);
      check("trap_sh", mem_err, 1);
`else
      issue(LH, 5'd13, 1'b1, 32'h101, 32'h0);
      ack(0, 32'hABCD8001);
      check("mis_lh_wn", wb_wn, 32'hFFFF8001);
      issue(LW, 5'd14, 1'b1, 32'h103, 32'h0);
      check("mis_lw_err", mem_err, 0);
      ack(0, 32'h12345678);
      check("mis_lw_wn", wb_wn, 32'h12345678);
      issue(SH, 5'd0, 1'b0, 32'h101, 32'h0000BEEF);
      check("mis_sh_strb", mem_wstrb, 4'b0110);
      check("mis_sh_wdata", mem_wdata, 32'hBEEFBEEF);
      ack(0, 32'h0);
`endif

      issue(NONE, 5'd1, 1'b1, 32'h11, 32'h0);
      issue(NONE, 5'd2, 1'b1, 32'h22, 32'h0);
      check("b2b_wa", wb_wa, 2);
      check("b2b_wn", wb_wn, 32'h22);

      repeat (3) @(posedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
